// File: rtl/data_bus_pkg.sv
// Shared types and helpers for data-bus responders.
// Address-window decode lives here so that other responders can reuse it.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    RESP  = 2'd2
  } resp_state_e;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  // Assumes start is aligned to size and size is a power of two.
  function automatic logic in_window(input logic [BUS_AW-1:0] addr,
                                     input logic [BUS_AW-1:0] start,
                                     input logic [BUS_AW-1:0] size);
    return (addr & ~(size - 32'd1)) == start;
  endfunction

endpackage

// File: rtl/data_bus_responder.sv
// Responder end of the core data bus (req/gnt/rvalid) in front of a 1-cycle SRAM.
// One outstanding transaction, optional wait states before grant, window decode.
//
// state | meaning
// IDLE  | no transaction; grants immediately when WAIT_CYCLES is 0
// STALL | counting wait states before grant
// RESP  | response cycle: rvalid_o high, no grant
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter logic [31:0] MEM_START   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE    = 8192,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int unsigned AW         = $clog2(MEM_SIZE / 4)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  if (MEM_SIZE < 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0 ||
      (MEM_START & (MEM_SIZE - 1)) != 0 || WAIT_CYCLES > 15) begin : g_bad_cfg
    $error("data_bus_responder: illegal MEM_START/MEM_SIZE/WAIT_CYCLES");
  end

  resp_state_e   r_state;
  resp_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_err;
  logic          w_in_range;
  logic          w_gnt;

  assign w_in_range = in_window(addr_i, MEM_START, MEM_SIZE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            w_gnt       = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = STALL;
          end
        end
      end
      STALL: begin
        // An initiator withdrawing its request is abandoned without any access.
        if (!req_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_gnt       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && req_i && WAIT_CYCLES != 0) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == STALL && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_gnt) begin
        r_we  <= we_i;
        r_err <= ~w_in_range;
      end
    end
  end

  // Request-side outputs are forced low while reset is held.
  assign gnt_o       = w_gnt & rst_ni;
  assign mem_req_o   = gnt_o & w_in_range;
  assign mem_we_o    = we_i & rst_ni;
  assign mem_be_o    = be_i & {4{rst_ni}};
  assign mem_addr_o  = addr_i[AW+1:2] & {AW{rst_ni}};
  assign mem_wdata_o = wdata_i & {32{rst_ni}};

  assign rvalid_o = (r_state == RESP);
  assign err_o    = rvalid_o & r_err;
  assign rdata_o  = (rvalid_o && !r_we && !r_err) ? mem_rdata_i : 32'h0;

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder (slave) end of the core's data-bus req/gnt/rvalid protocol.
- Sits between the core's data port and a single-port SRAM with 1-cycle read latency.
- Grants requests, optionally inserts configurable wait states, and decodes the address window.
- Drives the SRAM and returns rvalid/rdata, raising err for accesses outside the window.

Parameters:
- MEM_START, 32'h00000000, base byte address of the window; must be aligned to MEM_SIZE.
- MEM_SIZE, 8192, window size in bytes; must be a power of two ≥ 4.
- WAIT_CYCLES, 0, stall cycles inserted before gnt (0..15).
- AW, $clog2(MEM_SIZE/4), SRAM word-address width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request from initiator
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid (one cycle per granted request)
- rdata_o  out  32  read data
- err_o  out  1  error response, qualified by rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  AW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - Outputs: all outputs 0.
  - Internal state: state = IDLE, wait counter = 0, captured we/err flags = 0.
- Address decode: in_range = ((addr_i & ~(MEM_SIZE-1)) == MEM_START). Elaboration-time assertion fails if MEM_START is misaligned or MEM_SIZE is not a power of two.
- Address mapping: mem_addr_o = addr_i[AW+1:2]; addr_i[1:0] are ignored. mem_we_o, mem_be_o and mem_wdata_o pass through combinationally from the request inputs.
- Outstanding transactions: at most one; no new grant while a response is pending.
- FSM states: IDLE, STALL, RESP.
  - IDLE, req_i=1, WAIT_CYCLES=0: gnt_o=1 combinationally; capture we_i and !in_range; next state RESP.
  - IDLE, req_i=1, WAIT_CYCLES>0: gnt_o=0; counter <= WAIT_CYCLES-1; next state STALL.
  - STALL: gnt_o=0 while counter≠0; counter decrements each cycle.
    - Counter==0 and req_i=1: gnt_o=1, capture as in IDLE, next state RESP.
    - req_i drops in STALL (protocol violation): return to IDLE; no SRAM access, no response.
  - RESP: rvalid_o=1 for exactly one cycle; gnt_o=0 regardless of req_i; next state IDLE.
- SRAM strobe: mem_req_o = gnt_o & in_range. An out-of-range access never touches the SRAM.
- Response data:
  - Read in range: rdata_o = mem_rdata_i.
  - Write in range: rdata_o = 0, err_o = 0.
  - Out of range: rdata_o = 0, err_o = 1.
  - Whenever rvalid_o = 0: rdata_o = 0 and err_o = 0.
- Latency:
  - Grant: WAIT_CYCLES cycles after req_i rises.
  - Response: rvalid_o exactly 1 cycle after gnt_o.
  - Peak throughput: one transaction per 2 cycles with WAIT_CYCLES=0.
- Back-to-back: req_i held high during RESP is granted in the following IDLE cycle, or enters STALL there.
- Reset mid-operation: any state → IDLE immediately.
  - A pending response is dropped; rvalid_o is low from reset assertion.
  - An SRAM write already strobed has completed; nothing is replayed.
- Wait-counter width: $clog2(WAIT_CYCLES+1), minimum 1. The counter never wraps (loaded only from IDLE).

Decomposition:
- Shared package data_bus_pkg:
  - resp_state_e enum {IDLE, STALL, RESP}.
  - Width constants BUS_AW=32, BUS_DW=32, BUS_BEW=4.
  - Function in_window(addr, start, size), reused by future peripheral responders.
- Single module; no sub-module is natural. The wait counter stays inline.

Test Plan:
- WAIT_CYCLES=0, write 0xDEADBEEF to 0x00000010 with be=4'hF, then read 0x10 → gnt same cycle as req; mem_addr_o=4; read rvalid 1 cycle after gnt; rdata_o=0xDEADBEEF; err_o=0.
- WAIT_CYCLES=3, read 0x20 → gnt 3 cycles after req rises; rvalid exactly 1 cycle after gnt; gnt never asserted in RESP.
- Read 0x00002000 (MEM_SIZE=8192) → gnt=1, mem_req_o=0, rvalid=1 with err_o=1, rdata_o=0.
- req_i held high for 4 back-to-back reads at 0x0, 0x4, 0x8, 0xC, WAIT_CYCLES=0 → grants on cycles 0/2/4/6, rvalid on 1/3/5/7, data in order.
- WAIT_CYCLES=5, drop req_i in STALL after 2 cycles → no gnt, no mem_req_o, no rvalid; FSM back in IDLE; next request serviced normally.
- Assert rst_ni in RESP → rvalid_o, gnt_o and err_o go to 0 asynchronously; after release, a read of 0x10 returns the previously written data.
